// File: rtl/emif_csr_pkg.sv
// Shared types and constants for the EMIF CSR responder.
package emif_csr_pkg;

    localparam int unsigned CSR_AW = 5;
    localparam int unsigned CSR_DW = 64;

    localparam logic [CSR_AW-1:0] EMIF_DFH_OFFSET        = 5'h00;
    localparam logic [CSR_AW-1:0] EMIF_STATUS_OFFSET     = 5'h08;
    localparam logic [CSR_AW-1:0] EMIF_CAPABILITY_OFFSET = 5'h10;
    localparam logic [CSR_AW-1:0] EMIF_CONTROL_OFFSET    = 5'h18;

    localparam int unsigned STS_FAIL_LSB     = 8;
    localparam int unsigned STS_ACK_SEEN_BIT = 32;
    localparam int unsigned STS_ACK_TO_BIT   = 33;
    localparam int unsigned STS_STATE_LSB    = 34;

    localparam logic [3:0] DFH_FEAT_TYPE = 4'h3;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next_ofs;
        logic [3:0]  rev;
        logic [11:0] feat_id;
    } t_dfh;

    typedef enum logic [2:0] {
        ST_RST_REQ  = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_REL      = 3'd2,
        ST_WAIT_CAL = 3'd3,
        ST_READY    = 3'd4
    } t_emif_state;

    // READY shares the WAIT_CAL code; emif_ready distinguishes them.
    function automatic logic [1:0] state_code(input t_emif_state s);
        return (s == ST_READY) ? 2'd3 : s[1:0];
    endfunction

endpackage

// File: rtl/emif_rst_seq.sv
// mem_ss reset handshake sequencer with ack timeout and calibration tracking.
module emif_rst_seq
    import emif_csr_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rerst_i,
    input  logic              to_clr_i,
    input  logic              mem_ss_rst_ack_n_i,
    input  logic [NUM_CH-1:0] cal_success_i,
    input  logic [NUM_CH-1:0] cal_fail_i,
    output logic              mem_ss_rst_req_o,
    output logic              emif_ready_o,
    output logic              ack_seen_o,
    output logic              ack_to_o,
    output logic [1:0]        state_code_c,
    output logic [NUM_CH-1:0] cal_ok_vis_c,
    output logic [NUM_CH-1:0] cal_fail_vis_c
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;

    logic              ack_n_s1_q, ack_n_q;
    logic [NUM_CH-1:0] cal_ok_s1_q, cal_ok_q;
    logic [NUM_CH-1:0] cal_fail_s1_q, cal_fail_q;

    t_emif_state       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_seen_q, ack_seen_d;
    logic              ack_to_q, ack_to_d;
    logic              req_q, req_d;
    logic              ready_q, ready_d;
    logic              cal_vis;

    // Two-flop synchronizers for the mem_ss async inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_n_s1_q    <= 1'b1;
            ack_n_q       <= 1'b1;
            cal_ok_s1_q   <= '0;
            cal_ok_q      <= '0;
            cal_fail_s1_q <= '0;
            cal_fail_q    <= '0;
        end else begin
            ack_n_s1_q    <= mem_ss_rst_ack_n_i;
            ack_n_q       <= ack_n_s1_q;
            cal_ok_s1_q   <= cal_success_i;
            cal_ok_q      <= cal_ok_s1_q;
            cal_fail_s1_q <= cal_fail_i;
            cal_fail_q    <= cal_fail_s1_q;
        end
    end

    // FSM state, timeout counter and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST_REQ;
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            ack_to_q   <= 1'b0;
            req_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_seen_q <= ack_seen_d;
            ack_to_q   <= ack_to_d;
            req_q      <= req_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic; req/ready are registered from the next state so they track transitions on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_seen_d = ack_seen_q;
        ack_to_d   = ack_to_q;
        if (to_clr_i) begin
            ack_to_d = 1'b0;
        end
        case (state_q)
            ST_RST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!ack_n_q) begin
                    ack_seen_d = 1'b1;
                    state_d    = ST_REL;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    ack_to_d = 1'b1;
                    state_d  = ST_REL;
                end
            end
            ST_REL: begin
                if (ack_n_q) begin
                    state_d = ST_WAIT_CAL;
                end
            end
            ST_WAIT_CAL: begin
                if (&cal_ok_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (!(&cal_ok_q)) begin
                    state_d = ST_WAIT_CAL;
                end
            end
            default: state_d = ST_RST_REQ;
        endcase
        if (rerst_i) begin
            state_d    = ST_RST_REQ;
            ack_seen_d = 1'b0;
        end
        req_d   = (state_d == ST_RST_REQ) || (state_d == ST_WAIT_ACK);
        ready_d = (state_d == ST_READY);
    end

    // Calibration status is only meaningful once mem_ss is out of reset.
    always_comb begin
        cal_vis        = (state_q == ST_WAIT_CAL) || (state_q == ST_READY);
        cal_ok_vis_c   = cal_vis ? cal_ok_q : '0;
        cal_fail_vis_c = cal_vis ? cal_fail_q : '0;
        state_code_c   = state_code(state_q);
    end

    assign mem_ss_rst_req_o = req_q;
    assign emif_ready_o     = ready_q;
    assign ack_seen_o       = ack_seen_q;
    assign ack_to_o         = ack_to_q;

endmodule

// File: rtl/emif_csr_responder.sv
// EMIF feature CSR block: DFH/STATUS/CAPABILITY/CONTROL decode over the mem_ss reset sequencer.
module emif_csr_responder
    import emif_csr_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter logic [11:0] FEAT_ID      = 12'h9,
    parameter logic [23:0] NEXT_DFH_OFS = 24'h0,
    parameter logic        END_OF_LIST  = 1'b1,
    parameter int unsigned ACK_TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_wr,
    input  logic              csr_rd,
    input  logic [4:0]        csr_addr,
    input  logic [63:0]       csr_wdata,
    output logic              csr_rvalid,
    output logic [63:0]       csr_rdata,
    output logic              mem_ss_rst_req,
    input  logic              mem_ss_rst_ack_n,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic              emif_ready
);

    logic              rerst, to_clr;
    logic              ack_seen, ack_to;
    logic [1:0]        state_code_c;
    logic [NUM_CH-1:0] cal_ok_vis_c, cal_fail_vis_c;
    t_dfh              dfh;
    logic [63:0]       status, capability, rd_mux;
    logic              rvalid_q;
    logic [63:0]       rdata_q;
    logic              unused_wdata;

    assign unused_wdata = ^{csr_wdata[63:34], csr_wdata[32:1]};

    // Write side: only CONTROL bit0 and the STATUS timeout W1C have effect.
    assign rerst  = csr_wr && (csr_addr == EMIF_CONTROL_OFFSET) && csr_wdata[0];
    assign to_clr = csr_wr && (csr_addr == EMIF_STATUS_OFFSET) && csr_wdata[STS_ACK_TO_BIT];

    emif_rst_seq #(
        .NUM_CH      (NUM_CH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_rst_seq (
        .clk                (clk),
        .rst_n              (rst_n),
        .rerst_i            (rerst),
        .to_clr_i           (to_clr),
        .mem_ss_rst_ack_n_i (mem_ss_rst_ack_n),
        .cal_success_i      (cal_success),
        .cal_fail_i         (cal_fail),
        .mem_ss_rst_req_o   (mem_ss_rst_req),
        .emif_ready_o       (emif_ready),
        .ack_seen_o         (ack_seen),
        .ack_to_o           (ack_to),
        .state_code_c       (state_code_c),
        .cal_ok_vis_c       (cal_ok_vis_c),
        .cal_fail_vis_c     (cal_fail_vis_c)
    );

    // Register images and read mux; reflects state before any same-cycle write.
    always_comb begin
        dfh           = '0;
        dfh.feat_type = DFH_FEAT_TYPE;
        dfh.eol       = END_OF_LIST;
        dfh.next_ofs  = NEXT_DFH_OFS;
        dfh.feat_id   = FEAT_ID;

        status                                 = '0;
        status[NUM_CH-1:0]                     = cal_ok_vis_c;
        status[STS_FAIL_LSB +: NUM_CH]         = cal_fail_vis_c;
        status[STS_ACK_SEEN_BIT]               = ack_seen;
        status[STS_ACK_TO_BIT]                 = ack_to;
        status[STS_STATE_LSB +: 2]             = state_code_c;

        capability             = '0;
        capability[NUM_CH-1:0] = '1;

        case (csr_addr)
            EMIF_DFH_OFFSET:        rd_mux = dfh;
            EMIF_STATUS_OFFSET:     rd_mux = status;
            EMIF_CAPABILITY_OFFSET: rd_mux = capability;
            default:                rd_mux = '0;
        endcase
    end

    // Read response: one-cycle valid pulse, data held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= csr_rd;
            if (csr_rd) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign csr_rvalid = rvalid_q;
    assign csr_rdata  = rdata_q;

endmodule

// File: tb/tb_emif_csr_responder.sv
// Directed self-checking bench for emif_csr_responder.
module tb_emif_csr_responder;

    logic        clk;
    logic        rst_n;
    logic        csr_wr;
    logic        csr_rd;
    logic [4:0]  csr_addr;
    logic [63:0] csr_wdata;
    logic        csr_rvalid;
    logic [63:0] csr_rdata;
    logic        mem_ss_rst_req;
    logic        mem_ss_rst_ack_n;
    logic [1:0]  cal_success;
    logic [1:0]  cal_fail;
    logic        emif_ready;

    int n_vec = 0;
    int n_err = 0;

    emif_csr_responder #(.NUM_CH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_wr           (csr_wr),
        .csr_rd           (csr_rd),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .csr_rvalid       (csr_rvalid),
        .csr_rdata        (csr_rdata),
        .mem_ss_rst_req   (mem_ss_rst_req),
        .mem_ss_rst_ack_n (mem_ss_rst_ack_n),
        .cal_success      (cal_success),
        .cal_fail         (cal_fail),
        .emif_ready       (emif_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [63:0] d, output logic v);
        csr_rd   = 1'b1;
        csr_addr = a;
        tick(1);
        csr_rd = 1'b0;
        v = csr_rvalid;
        d = csr_rdata;
    endtask

    task automatic csr_write(input logic [4:0] a, input logic [63:0] wd);
        csr_wr    = 1'b1;
        csr_addr  = a;
        csr_wdata = wd;
        tick(1);
        csr_wr    = 1'b0;
        csr_wdata = '0;
    endtask

    initial begin
        logic [63:0] d;
        logic        v;
        logic [1:0]  code, last;
        logic [7:0]  walk;
        int          n_tr, nwait;
        bit          saw_rel, done, found;

        rst_n = 1'b0; csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = '0; csr_wdata = '0;
        mem_ss_rst_ack_n = 1'b1; cal_success = 2'b00; cal_fail = 2'b00;
        last = 2'b00; walk = '0; n_tr = 0;

        // Reset values
        #22;
        chk("rst_req",    64'(mem_ss_rst_req), 64'd1);
        chk("rst_ready",  64'(emif_ready),     64'd0);
        chk("rst_rvalid", 64'(csr_rvalid),     64'd0);
        chk("rst_rdata",  csr_rdata,           64'd0);

        // Handshake: continuous STATUS reads while ack_n pulses low 20..29
        @(posedge clk); #1;
        csr_rd = 1'b1; csr_addr = 5'h08;
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            code = csr_rdata[35:34];
            if (i == 1 || code != last) begin
                walk = {walk[5:0], code};
                n_tr++;
                last = code;
            end
            if (i == 22) chk("req_before_ack", 64'(mem_ss_rst_req), 64'd1);
            if (i == 23) chk("req_after_ack",  64'(mem_ss_rst_req), 64'd0);
            if (i == 20) mem_ss_rst_ack_n = 1'b0;
            if (i == 30) mem_ss_rst_ack_n = 1'b1;
        end
        csr_rd = 1'b0;
        chk("state_walk",  64'(walk), 64'h1B);
        chk("state_steps", 64'(n_tr), 64'd4);
        chk("ack_seen",    64'(csr_rdata[32]), 64'd1);
        chk("no_timeout",  64'(csr_rdata[33]), 64'd0);
        chk("req_low",     64'(mem_ss_rst_req), 64'd0);

        // Calibration: one channel, then both
        cal_success = 2'b01;
        tick(3);
        chk("ready_partial", 64'(emif_ready), 64'd0);
        csr_read(5'h08, d, v);
        chk("sts_partial", d, 64'h0000_000D_0000_0001);
        cal_success = 2'b11;
        tick(2);
        chk("ready_lat2", 64'(emif_ready), 64'd0);
        tick(1);
        chk("ready_lat3", 64'(emif_ready), 64'd1);
        csr_read(5'h08, d, v);
        chk("sts_ready", d, 64'h0000_000D_0000_0003);
        cal_fail = 2'b10;
        tick(2);
        csr_read(5'h08, d, v);
        chk("sts_calfail", d, 64'h0000_000D_0000_0203);
        cal_fail = 2'b00;
        tick(2);

        // Static registers and unmapped offsets
        csr_read(5'h10, d, v);
        chk("cap", d, 64'h3);
        csr_write(5'h00, '1);
        csr_read(5'h00, d, v);
        chk("dfh", d, 64'h3000_0100_0000_0009);
        chk("dfh_rvalid", 64'(v), 64'd1);
        tick(1);
        chk("rvalid_pulse", 64'(csr_rvalid), 64'd0);
        csr_read(5'h1C, d, v);
        chk("unmapped_data",   d,      64'h0);
        chk("unmapped_rvalid", 64'(v), 64'd1);
        csr_read(5'h18, d, v);
        chk("control_rd", d, 64'h0);

        // Re-reset from READY with ack_n held high -> timeout path
        csr_write(5'h18, 64'h1);
        chk("rerst_req",   64'(mem_ss_rst_req), 64'd1);
        chk("rerst_ready", 64'(emif_ready),     64'd0);
        csr_rd = 1'b1; csr_addr = 5'h08;
        nwait = 0; saw_rel = 1'b0; done = 1'b0;
        for (int k = 0; k < 6000 && !done; k++) begin
            @(posedge clk); #1;
            d = csr_rdata;
            code = d[35:34];
            if (k == 0) chk("sts_after_rerst", d, 64'h0);
            if (code == 2'd1) nwait++;
            if (code == 2'd2 && !saw_rel) begin
                saw_rel = 1'b1;
                chk("timeout_flag", 64'(d[33]), 64'd1);
                chk("timeout_seen", 64'(d[32]), 64'd0);
            end
            if (code == 2'd3) done = 1'b1;
        end
        csr_rd = 1'b0;
        chk("timeout_reached_cal", 64'(done), 64'd1);
        chk("timeout_cycles", 64'(nwait), 64'd4096);
        tick(2);
        chk("ready_after_to", 64'(emif_ready), 64'd1);

        // Simultaneous read and W1C of the timeout flag
        csr_rd = 1'b1; csr_wr = 1'b1; csr_addr = 5'h08; csr_wdata = 64'h2_0000_0000;
        tick(1);
        csr_rd = 1'b0; csr_wr = 1'b0; csr_wdata = '0;
        chk("w1c_same_cycle", csr_rdata, 64'h0000_000E_0000_0003);
        csr_read(5'h08, d, v);
        chk("w1c_cleared", d, 64'h0000_000C_0000_0003);

        // Calibration drop while READY
        cal_success = 2'b01;
        tick(2);
        chk("drop_lat2", 64'(emif_ready), 64'd1);
        tick(1);
        chk("drop_lat3", 64'(emif_ready), 64'd0);
        cal_success = 2'b11;
        tick(3);

        // Async reset while req is released mid-handshake
        mem_ss_rst_ack_n = 1'b0;
        csr_write(5'h18, 64'h1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (!mem_ss_rst_req) found = 1'b1;
        end
        chk("rel_reached", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req",   64'(mem_ss_rst_req), 64'd1);
        chk("async_rst_ready", 64'(emif_ready),     64'd0);
        mem_ss_rst_ack_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
